// File: rtl/sync_filter_bits_if.sv
// Pin-conditioner bus: sample strobe and raw pins in,
// filtered levels and registered edge pulses out.
interface sync_filter_bits_if #(
  parameter int WIDTH = 8
);
  logic             EN;
  logic [WIDTH-1:0] D_IN;
  logic [WIDTH-1:0] D_OUT;
  logic [WIDTH-1:0] RISE;
  logic [WIDTH-1:0] FALL;
  logic             CHG;

  modport master (
    output EN,
    output D_IN,
    input  D_OUT,
    input  RISE,
    input  FALL,
    input  CHG
  );

  modport slave (
    input  EN,
    input  D_IN,
    output D_OUT,
    output RISE,
    output FALL,
    output CHG
  );
endinterface

// File: rtl/sync_filter_bits.sv
// Per-bit synchroniser chain plus stability filter for async pins.
// Define SYNC_FILTER_EDGE_EN to build the RISE/FALL/CHG registers.
module sync_filter_bits #(
  parameter int               WIDTH  = 8,
  parameter int               STAGES = 2,
  parameter int               FILT   = 4,
  parameter logic [WIDTH-1:0] init   = '0
) (
  input logic               CLK,
  input logic               RST_N,
  sync_filter_bits_if.slave bus
);

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(FILT - 1);

  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic [WIDTH-1:0] sync;

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dout_d;

  assign sync = s_q[STAGES-1];

  always_comb begin
    s_d[0] = bus.D_IN;
    for (int k = 1; k < STAGES; k++) begin
      s_d[k] = s_q[k-1];
    end
  end

  // A matching enabled sample restarts the run; EN=0 holds.
  always_comb begin
    dout_d = dout_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.EN) begin
        if (sync[i] == dout_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CMAX) begin
          dout_d[i] = sync[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int k = 0; k < STAGES; k++) begin
        s_q[k] <= init;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      dout_q <= init;
    end else begin
      s_q    <= s_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign bus.D_OUT = dout_q;

`ifdef SYNC_FILTER_EDGE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic             chg_q;
  logic             chg_d;

  // Pulses come from the next-state compare, so they land
  // on the same edge as the D_OUT update.
  always_comb begin
    rise_d = dout_d & ~dout_q;
    fall_d = ~dout_d & dout_q;
    chg_d  = |(rise_d | fall_d);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= chg_d;
    end
  end

  assign bus.RISE = rise_q;
  assign bus.FALL = fall_q;
  assign bus.CHG  = chg_q;
`else
  assign bus.RISE = '0;
  assign bus.FALL = '0;
  assign bus.CHG  = 1'b0;
`endif

endmodule
